alu: RTL and testbench

- Registered 8-function arithmetic/logic unit operating on two unsigned WIDTH-bit operands.
- Produces a 2*WIDTH-bit result one clock after the operands and opcode are presented.
- Used as a small datapath leaf; a bench drives it with random operand/opcode triples and samples the output each cycle.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_core.sv | 64 ++++++
 rtl/alu.sv | 70 +++++++
 tb/tb_alu.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and CMP result bit positions for the registered ALU.
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_ADD = 3'b000;
    localparam alu_op_t OP_SUB = 3'b001;
    localparam alu_op_t OP_MUL = 3'b010;
    localparam alu_op_t OP_AND = 3'b011;
    localparam alu_op_t OP_OR  = 3'b100;
    localparam alu_op_t OP_XOR = 3'b101;
    localparam alu_op_t OP_CMP = 3'b110;
    localparam alu_op_t OP_SHL = 3'b111;

    localparam int unsigned CMP_LT = 0;
    localparam int unsigned CMP_EQ = 1;
    localparam int unsigned CMP_GT = 2;

endpackage

// File: rtl/alu_core.sv
// Combinational next-result logic: operands are zero-extended to 2*WIDTH bits.
// Optional zero/carry flags are built only when ALU_FLAGS_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [2:0]         sel_i,
    output logic [2*WIDTH-1:0] result_o
`ifdef ALU_FLAGS_EN
    ,
    output logic               zero_o,
    output logic               carry_o
`endif
);

    localparam int RW = 2 * WIDTH;

    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;
    logic [RW-1:0] sum;
    logic [RW-1:0] diff;

    assign a_ext = {{WIDTH{1'b0}}, a_i};
    assign b_ext = {{WIDTH{1'b0}}, b_i};
    assign sum   = a_ext + b_ext;
    // Subtracting in the wide domain gives the two's-complement result directly.
    assign diff  = a_ext - b_ext;

    always_comb begin
        result_o = '0;
        case (sel_i)
            OP_ADD: result_o = sum;
            OP_SUB: result_o = diff;
            OP_MUL: result_o = a_ext * b_ext;
            OP_AND: result_o = a_ext & b_ext;
            OP_OR:  result_o = a_ext | b_ext;
            OP_XOR: result_o = a_ext ^ b_ext;
            OP_CMP: begin
                result_o[CMP_LT] = (a_i < b_i);
                result_o[CMP_EQ] = (a_i == b_i);
                result_o[CMP_GT] = (a_i > b_i);
            end
            // Only the low three bits of b form the shift amount.
            OP_SHL: result_o = a_ext << b_i[2:0];
            default: result_o = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    always_comb begin
        zero_o  = (result_o == '0);
        carry_o = 1'b0;
        if (sel_i == OP_ADD) begin
            carry_o = sum[WIDTH];
        end else if (sel_i == OP_SUB) begin
            carry_o = (a_i < b_i);
        end
    end
`endif

endmodule

// File: rtl/alu.sv
// Registered ALU top: one-cycle latency, synchronous active-high reset to zero.
// Defining ALU_FLAGS_EN adds registered zero_flag and carry_flag outputs.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         alu_sel,
    output logic [2*WIDTH-1:0] alu_out
`ifdef ALU_FLAGS_EN
    ,
    output logic               zero_flag,
    output logic               carry_flag
`endif
);

    logic [2*WIDTH-1:0] alu_out_d;
    logic [2*WIDTH-1:0] alu_out_q;

`ifdef ALU_FLAGS_EN
    logic zero_d;
    logic zero_q;
    logic carry_d;
    logic carry_q;
`endif

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (a),
        .b_i      (b),
        .sel_i    (alu_sel),
        .result_o (alu_out_d)
`ifdef ALU_FLAGS_EN
        ,
        .zero_o   (zero_d),
        .carry_o  (carry_d)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q <= '0;
        end else begin
            alu_out_q <= alu_out_d;
        end
    end

    assign alu_out = alu_out_q;

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed and back-to-back random checks of the registered ALU (WIDTH=4).
module tb_alu;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
`ifdef ALU_FLAGS_EN
    logic       zero_flag;
    logic       carry_flag;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
`ifdef ALU_FLAGS_EN
    logic [1:0] flag_q[$];
`endif

    alu #(
        .WIDTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .alu_sel (alu_sel),
        .alu_out (alu_out)
`ifdef ALU_FLAGS_EN
        ,
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
`endif
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst     = 1'b1;
        a       = 4'h0;
        b       = 4'h0;
        alu_sel = 3'b000;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 8'h%02h expected 8'h%02h", tag, got, exp);
        end
    endtask

    // Independent reference written with integer arithmetic.
    function automatic logic [7:0] ref_alu(input logic [3:0] x, input logic [3:0] y,
                                           input logic [2:0] s);
        int xi;
        int yi;
        int r;
        xi = int'(x);
        yi = int'(y);
        case (s)
            3'd0: r = xi + yi;
            3'd1: r = (xi - yi + 256) % 256;
            3'd2: r = xi * yi;
            3'd3: r = int'(x & y);
            3'd4: r = int'(x | y);
            3'd5: r = int'(x ^ y);
            3'd6: r = (xi < yi) ? 1 : ((xi == yi) ? 2 : 4);
            default: r = (xi * (1 << (yi % 8))) % 256;
        endcase
        return r[7:0];
    endfunction

`ifdef ALU_FLAGS_EN
    function automatic logic [1:0] ref_flags(input logic [3:0] x, input logic [3:0] y,
                                             input logic [2:0] s);
        logic zf;
        logic cf;
        zf = (ref_alu(x, y, s) == 8'h00);
        cf = 1'b0;
        if (s == 3'd0) cf = (int'(x) + int'(y)) > 15;
        if (s == 3'd1) cf = (int'(x) < int'(y));
        return {zf, cf};
    endfunction
`endif

    // Driver: present inputs at negedge and queue the value expected after the next posedge.
    task automatic drive(input logic [3:0] x, input logic [3:0] y, input logic [2:0] s,
                         input logic r, input logic [7:0] exp);
        @(negedge clk);
        a       = x;
        b       = y;
        alu_sel = s;
        rst     = r;
        exp_q.push_back(exp);
`ifdef ALU_FLAGS_EN
        flag_q.push_back(r ? 2'b00 : ref_flags(x, y, s));
`endif
    endtask

    // Scoreboard: pop the oldest expectation and compare just after the edge.
    task automatic sample(input string tag);
        logic [7:0] e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, alu_out, e);
`ifdef ALU_FLAGS_EN
        begin
            logic [1:0] f;
            f = flag_q.pop_front();
            check({tag, "_zf"}, {7'h0, zero_flag}, {7'h0, f[1]});
            check({tag, "_cf"}, {7'h0, carry_flag}, {7'h0, f[0]});
        end
`endif
    endtask

    task automatic op(input string tag, input logic [3:0] x, input logic [3:0] y,
                      input logic [2:0] s, input logic [7:0] exp);
        drive(x, y, s, 1'b0, exp);
        sample(tag);
    endtask

    initial begin
        logic [7:0] prev;
        logic [3:0] rx;
        logic [3:0] ry;
        logic [2:0] rs;
        logic       rr;
        logic [7:0] re;

        // Reset held two cycles with a multiply pending.
        drive(4'hF, 4'hF, 3'b010, 1'b1, 8'h00);
        sample("rst_c0");
        drive(4'hF, 4'hF, 3'b010, 1'b1, 8'h00);
        sample("rst_c1");
        op("rst_release", 4'hF, 4'hF, 3'b010, 8'hE1);

        op("add_max",  4'hF, 4'hF, 3'b000, 8'h1E);
        op("sub_neg",  4'h3, 4'h5, 3'b001, 8'hFE);
        op("sub_pos",  4'h5, 4'h3, 3'b001, 8'h02);
        op("mul_max",  4'hF, 4'hF, 3'b010, 8'hE1);
        op("and",      4'hC, 4'hA, 3'b011, 8'h08);
        op("or",       4'hC, 4'hA, 3'b100, 8'h0E);
        op("xor",      4'hC, 4'hA, 3'b101, 8'h06);
        op("cmp_lt",   4'h5, 4'h9, 3'b110, 8'h01);
        op("cmp_eq",   4'h7, 4'h7, 3'b110, 8'h02);
        op("cmp_gt",   4'h9, 4'h5, 3'b110, 8'h04);
        op("shl_5",    4'hF, 4'h5, 3'b111, 8'hE0);
        op("shl_0",    4'h1, 4'h0, 3'b111, 8'h01);
        op("shl_mask", 4'h1, 4'hF, 3'b111, 8'h80);
        op("add_zero", 4'h0, 4'h0, 3'b000, 8'h00);
        op("sub_zero", 4'h8, 4'h8, 3'b001, 8'h00);

        // Back-to-back random triples; reset pulsed on cycle 10.
        prev = 8'h00;
        for (int i = 0; i < 20; i++) begin
            rx = 4'($urandom_range(0, 15));
            ry = 4'($urandom_range(0, 15));
            rs = 3'($urandom_range(0, 7));
            rr = (i == 10);
            re = rr ? 8'h00 : ref_alu(rx, ry, rs);
            drive(rx, ry, rs, rr, re);
            // Between edges the output must still hold the previous result.
            #1;
            check($sformatf("b2b_hold_%0d", i), alu_out, prev);
            sample($sformatf("b2b_%0d", i));
            prev = re;
        end

        @(negedge clk);
        rst = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
